ripple_carry_adder: RTL and testbench

- Parameterised N-bit ripple-carry adder built from a chain of 1-bit full adders: sum = a + b + c_in.
- Combinational carry chain; result and carry-out captured in an output register stage.
- Output carries a valid flag.
- Used as a datapath primitive in the matrix-multiplication accumulate path.

---
 rtl/ripple_carry_adder_pkg.sv | 15 +
 rtl/ripple_carry_adder_full_adder.sv | 20 ++
 rtl/ripple_carry_adder.sv | 70 +++++++
 tb/tb_ripple_carry_adder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ripple_carry_adder_pkg.sv
// Shared datapath constants and helpers for the ripple-carry adder.
// Imported by the adder top level.
package ripple_carry_adder_pkg;

   localparam int RCA_DEFAULT_WIDTH = 4;

   // Signed overflow: the carry into the MSB disagrees with the carry out.
   function automatic logic rca_ovf(
      input logic c_into_msb,
      input logic c_out_msb
   );
      return c_into_msb ^ c_out_msb;
   endfunction

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// One-bit full adder cell.
// Purely combinational link in the ripple carry chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s,
   output logic c_out
);

   logic p;

   // Propagate term, reused by the sum and carry logic.
   always_comb begin
      p     = a ^ b;
      s     = p ^ c_in;
      c_out = (a & b) | (c_in & p);
   end

endmodule

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder with a registered result stage.
// Result, carry out and signed overflow are captured with a valid flag.
module ripple_carry_adder
   import ripple_carry_adder_pkg::*;
#(
   parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             overflow,
   output logic             out_valid
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_d;
   logic             c_out_d;
   logic             ovf_d;

   logic [WIDTH-1:0] s_q;
   logic             c_out_q;
   logic             ovf_q;
   logic             valid_q;

   assign carry[0] = c_in;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      full_adder u_fa (
         .a     (a[i]),
         .b     (b[i]),
         .c_in  (carry[i]),
         .s     (sum_d[i]),
         .c_out (carry[i+1])
      );
   end

   // Next-state result taken from the end of the carry chain.
   always_comb begin
      c_out_d = carry[WIDTH];
      ovf_d   = rca_ovf(carry[WIDTH-1], carry[WIDTH]);
   end

   // Output stage: capture on valid, hold data while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q     <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            s_q     <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
         end
      end
   end

   assign s         = s_q;
   assign c_out     = c_out_q;
   assign overflow  = ovf_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder at WIDTH=4 and WIDTH=32.
// Driver pushes expected per-cycle outputs; a monitor pops and compares.
module tb_ripple_carry_adder;

   typedef struct packed {
      logic        v;
      logic [63:0] s;
      logic        c;
      logic        o;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [3:0]  a4, b4, s4;
   logic        ci4, co4, of4, ov4;
   logic [31:0] a32, b32, s32;
   logic        ci32, co32, of32, ov32;

   int   checks = 0;
   int   errors = 0;
   exp_t q4[$];
   exp_t q32[$];
   exp_t h4 = '0;
   exp_t h32 = '0;

   always #5 clk = ~clk;

   ripple_carry_adder #(.WIDTH(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a4),
      .b         (b4),
      .c_in      (ci4),
      .s         (s4),
      .c_out     (co4),
      .overflow  (of4),
      .out_valid (ov4)
   );

   ripple_carry_adder #(.WIDTH(32)) u_dut32 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a32),
      .b         (b32),
      .c_in      (ci32),
      .s         (s32),
      .c_out     (co32),
      .overflow  (of32),
      .out_valid (ov32)
   );

   // Reference: plain arithmetic, overflow from signed range check.
   function automatic exp_t model(
      input longint unsigned x,
      input longint unsigned y,
      input bit              cin,
      input int              w
   );
      exp_t        e;
      logic [64:0] full;
      longint      lim, sx, sy, tot;
      full = {1'b0, x} + {1'b0, y} + 65'(cin);
      e.v  = 1'b1;
      e.s  = full[63:0] & ((64'd1 << w) - 64'd1);
      e.c  = full[w];
      lim  = longint'(1) << (w - 1);
      sx   = longint'(x);
      sy   = longint'(y);
      if (sx >= lim) sx = sx - 2 * lim;
      if (sy >= lim) sy = sy - 2 * lim;
      tot  = sx + sy + longint'(cin);
      e.o  = (tot >= lim) || (tot < -lim);
      return e;
   endfunction

   task automatic step(
      input bit          r,
      input bit          v,
      input logic [3:0]  x4,
      input logic [3:0]  y4,
      input bit          z4,
      input logic [31:0] x32,
      input logic [31:0] y32,
      input bit          z32
   );
      exp_t e4, e32;
      @(negedge clk);
      rst      = r;
      in_valid = v;
      a4       = x4;
      b4       = y4;
      ci4      = z4;
      a32      = x32;
      b32      = y32;
      ci32     = z32;
      if (r) begin
         h4  = '0;
         h32 = '0;
         e4  = '0;
         e32 = '0;
      end else if (v) begin
         e4    = model(64'(x4), 64'(y4), z4, 4);
         e32   = model(64'(x32), 64'(y32), z32, 32);
         h4    = e4;
         h4.v  = 1'b0;
         h32   = e32;
         h32.v = 1'b0;
      end else begin
         e4  = h4;
         e32 = h32;
      end
      q4.push_back(e4);
      q32.push_back(e32);
   endtask

   task automatic chk(
      input string       n,
      input logic        v,
      input logic [63:0] sv,
      input logic        c,
      input logic        o,
      input exp_t        e
   );
      checks++;
      if (v !== e.v) begin
         errors++;
         $display("FAIL %s out_valid got %0b want %0b", n, v, e.v);
      end
      checks++;
      if (sv !== e.s) begin
         errors++;
         $display("FAIL %s s got %0h want %0h", n, sv, e.s);
      end
      checks++;
      if (c !== e.c) begin
         errors++;
         $display("FAIL %s c_out got %0b want %0b", n, c, e.c);
      end
      checks++;
      if (o !== e.o) begin
         errors++;
         $display("FAIL %s overflow got %0b want %0b", n, o, e.o);
      end
   endtask

   // Monitor: one expected entry per edge, sampled just after it.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q4.size() > 0) begin
         e = q4.pop_front();
         chk("w4", ov4, 64'(s4), co4, of4, e);
      end
      if (q32.size() > 0) begin
         e = q32.pop_front();
         chk("w32", ov32, 64'(s32), co32, of32, e);
      end
   end

   function automatic logic [31:0] r32();
      return 32'($urandom);
   endfunction

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      a4       = '0;
      b4       = '0;
      ci4      = 1'b0;
      a32      = '0;
      b32      = '0;
      ci32     = 1'b0;

      // reset held with operands present
      step(1, 1, 4'd9, 4'd9, 0, 32'd9, 32'd9, 0);
      step(1, 1, 4'd9, 4'd9, 0, 32'd9, 32'd9, 0);

      // directed sums
      step(0, 1, 4'd2, 4'd3, 1, 32'hFFFF_FFFF, 32'd0, 1);
      step(0, 1, 4'd0, 4'd0, 0, 32'h7FFF_FFFF, 32'd1, 0);
      step(0, 1, 4'd5, 4'd7, 0, 32'h8000_0000, 32'h8000_0000, 0);

      // idle: results must hold
      for (int i = 0; i < 3; i++)
         step(0, 0, 4'($urandom), 4'($urandom), 1, r32(), r32(), 1);

      step(0, 1, 4'd15, 4'd1,  0, r32(), r32(), 0);
      step(0, 1, 4'd15, 4'd15, 1, r32(), r32(), 1);
      step(0, 1, 4'd8,  4'd8,  0, r32(), r32(), 0);
      step(0, 1, 4'd7,  4'd0,  1, r32(), r32(), 1);

      // exhaustive WIDTH=4
      for (int i = 0; i < 512; i++) begin
         logic [8:0] k;
         k = 9'(i);
         step(0, 1, k[3:0], k[7:4], k[8], r32(), r32(), bit'($urandom));
      end

      // reset mid-stream discards the operands on that edge
      step(0, 1, 4'd3, 4'd4, 0, r32(), r32(), 0);
      step(1, 1, 4'd6, 4'd6, 1, r32(), r32(), 1);
      step(0, 0, 4'd1, 4'd1, 0, r32(), r32(), 0);

      // random traffic with occasional idle
      for (int i = 0; i < 10000; i++)
         step(0, bit'($urandom_range(9) != 0),
              4'($urandom), 4'($urandom), bit'($urandom),
              r32(), r32(), bit'($urandom));

      @(posedge clk);
      #3;
      checks++;
      if (q4.size() != 0 || q32.size() != 0) begin
         errors++;
         $display("FAIL drain pending got %0d want 0", q4.size() + q32.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
